// File: rtl/row_column_sum_tree_pkg.sv
// ---------------------------------------------------------------------------
// row_column_sum_tree_pkg
// Shared sizing helpers for the row/column signed reduction tree.
//   calc_levels      : adder-tree depth for a given row count
//   calc_sign_width  : width of one signed term after the sign stage
//   calc_csw         : width of one emitted column sum
//   calc_latency     : pipeline latency for a PIPED / stage-mask pair
// ---------------------------------------------------------------------------
package row_column_sum_tree_pkg;

  // One tree level per halving of the row count; a single row needs no adds.
  function automatic int calc_levels(input int num_rows);
    return (num_rows > 1) ? $clog2(num_rows) : 0;
  endfunction

  // One extra bit so that negating the most negative element is exact.
  function automatic int calc_sign_width(input int data_width);
    return data_width + 1;
  endfunction

  // Sign-stage width plus one bit per tree level plus one spare bit.
  function automatic int calc_csw(input int data_width, input int levels);
    return data_width + levels + 2;
  endfunction

  // Number of register slices actually built for a given configuration.
  function automatic int calc_latency(input int piped, input logic [31:0] mask,
                                      input int levels);
    int cnt;
    cnt = 0;
    if (piped != 0) begin
      for (int i = 0; i <= levels; i++) begin
        if (mask[i]) cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/row_column_sum_tree_adder_subtractor.sv
// ---------------------------------------------------------------------------
// adder_subtractor
// Combinational two's-complement adder / subtractor.
//   a, b     : operands, WIDTH bits
//   sub      : 0 -> result = a + b, 1 -> result = a - b
//   result   : WIDTH-bit sum or difference
//   cout     : carry out of the MSB (for a subtract this is "no borrow")
//   overflow : signed overflow of the operation
//   zero     : result is all zeros
// ---------------------------------------------------------------------------
module adder_subtractor
  import row_column_sum_tree_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;

  always_comb begin
    // Subtraction is a + ~b + 1, so the carry out naturally means "no borrow".
    b_eff    = sub ? ~b : b;
    full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    result   = full_sum[WIDTH-1:0];
    cout     = full_sum[WIDTH];
    // Signed overflow: both effective operands share a sign the result lacks.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    zero     = (result == '0);
  end

endmodule

// File: rtl/row_column_sum_tree.sv
// ---------------------------------------------------------------------------
// row_column_sum_tree
// Per-column signed reduction of NUM_ROWS coupling rows. Each valid row r
// contributes +j when sigma_bits[r]=1 and -j when sigma_bits[r]=0; invalid
// rows contribute nothing. One signed sum per column is produced together
// with a done strobe.
//
// Ports
//   clk           : clock
//   rst           : synchronous, active-high reset of every pipe register
//   j_rows        : NUM_ROWS x VECTOR_SIZE signed DATA_WIDTH-bit elements
//   j_rows_valid  : per-row valid
//   sigma_bits    : per-row spin, 1 = +1, 0 = -1
//   column_sums   : VECTOR_SIZE signed CSW-bit column sums (0 when !done)
//   done          : column_sums holds a result this cycle
//
// Flow: a row set is accepted every cycle (there is no ready). The set is
// "live" when any row valid is high; that bit travels down a valid pipe that
// has a register exactly where the data path has one, and emerges as done
// after L = popcount of the built register slices (0 when PIPED=0).
//
// Structure: level 0 is the sign stage, levels 1..LEVELS are pairwise adds
// over a row count padded with zeros to a power of two. Each level grows one
// bit, so no level can overflow. A register slice follows level l when
// PIPED and PIPE_STAGE_MASK[l] are both set.
// ---------------------------------------------------------------------------
module row_column_sum_tree
  import row_column_sum_tree_pkg::*;
#(
  parameter int              NUM_ROWS        = 4,
  parameter int              VECTOR_SIZE     = 256,
  parameter int              DATA_WIDTH      = 4,
  parameter int              PIPED           = 1,
  parameter int              LEVELS          = calc_levels(NUM_ROWS),
  parameter logic [LEVELS:0] PIPE_STAGE_MASK = '1,
  localparam int             CSW             = calc_csw(DATA_WIDTH, LEVELS)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NUM_ROWS-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_rows,
  input  logic [NUM_ROWS-1:0]                                j_rows_valid,
  input  logic [NUM_ROWS-1:0]                                sigma_bits,
  output logic [VECTOR_SIZE-1:0][CSW-1:0]                    column_sums,
  output logic                                               done
);

  localparam int SW     = calc_sign_width(DATA_WIDTH);
  localparam int PADDED = 1 << LEVELS;
  localparam int FW     = SW + LEVELS;

  // A fully combinational build has no registers; keep clk/rst referenced.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // -------------------------------------------------------------------------
  // Level l holds PADDED>>l nodes per column, each SW+l bits wide. "stage" is
  // what the next level (or the output) sees: the registered copy when a
  // slice is built after this level, otherwise the combinational value.
  // -------------------------------------------------------------------------
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = SW + l;
    localparam int N = PADDED >> l;

    logic [W-1:0] sum_d [VECTOR_SIZE][N];
    logic [W-1:0] stage [VECTOR_SIZE][N];
    logic         vld_d;
    logic         vld_stage;

    if (l == 0) begin : g_sign
      assign vld_d = |j_rows_valid;

      for (genvar c = 0; c < VECTOR_SIZE; c++) begin : g_col
        for (genvar r = 0; r < N; r++) begin : g_row
          if (r < NUM_ROWS) begin : g_live
            logic [W-1:0] ext;
            assign ext = {j_rows[r][c][DATA_WIDTH-1], j_rows[r][c]};
            // The extra bit makes -(-2^(DATA_WIDTH-1)) representable.
            assign sum_d[c][r] = !j_rows_valid[r] ? '0 :
                                 sigma_bits[r]    ? ext : -ext;
          end else begin : g_pad
            assign sum_d[c][r] = '0;
          end
        end
      end
    end else begin : g_tree
      assign vld_d = g_lvl[l-1].vld_stage;

      for (genvar c = 0; c < VECTOR_SIZE; c++) begin : g_col
        for (genvar n = 0; n < N; n++) begin : g_node
          logic [W-1:0] op_a;
          logic [W-1:0] op_b;
          logic [2:0]   unused_flags;

          // Sign-extend the two children by one bit before adding.
          assign op_a = {g_lvl[l-1].stage[c][2*n][W-2],   g_lvl[l-1].stage[c][2*n]};
          assign op_b = {g_lvl[l-1].stage[c][2*n+1][W-2], g_lvl[l-1].stage[c][2*n+1]};

          adder_subtractor #(
            .WIDTH (W)
          ) u_add (
            .a        (op_a),
            .b        (op_b),
            .sub      (1'b0),
            .result   (sum_d[c][n]),
            .cout     (unused_flags[0]),
            .overflow (unused_flags[1]),
            .zero     (unused_flags[2])
          );
        end
      end
    end

    if ((PIPED != 0) && PIPE_STAGE_MASK[l]) begin : g_reg
      logic [W-1:0] sum_q [VECTOR_SIZE][N];
      logic         vld_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int c = 0; c < VECTOR_SIZE; c++) begin
            for (int n = 0; n < N; n++) begin
              sum_q[c][n] <= '0;
            end
          end
          vld_q <= 1'b0;
        end else begin
          sum_q <= sum_d;
          vld_q <= vld_d;
        end
      end

      assign stage     = sum_q;
      assign vld_stage = vld_q;
    end else begin : g_wire
      assign stage     = sum_d;
      assign vld_stage = vld_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output: root of the tree, sign-extended to CSW, forced to zero when idle.
  // -------------------------------------------------------------------------
  logic [FW-1:0] final_sum [VECTOR_SIZE];

  for (genvar c = 0; c < VECTOR_SIZE; c++) begin : g_out
    assign final_sum[c] = g_lvl[LEVELS].stage[c][0];
  end

  assign done = g_lvl[LEVELS].vld_stage;

  always_comb begin
    column_sums = '0;
    if (done) begin
      for (int c = 0; c < VECTOR_SIZE; c++) begin
        column_sums[c] = {{(CSW-FW){final_sum[c][FW-1]}}, final_sum[c]};
      end
    end
  end

endmodule

// File: tb/tb_row_column_sum_tree.sv
// ---------------------------------------------------------------------------
// tb_row_column_sum_tree
// Drives a pipelined instance (mask 3'b111, latency 3) and a combinational
// instance (PIPED=0) from the same inputs, plus a standalone 8-bit
// adder_subtractor. Expected column sums come from integer arithmetic over
// the rows; the pipelined path is checked through a three-deep expected queue.
// ---------------------------------------------------------------------------
module tb_row_column_sum_tree;

  localparam int NR   = 4;
  localparam int VS   = 8;
  localparam int DW   = 4;
  localparam int CSW  = 8;
  localparam int LAT  = 3;
  localparam int SBW  = VS * CSW + 1;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ DUT wiring
  logic [NR-1:0][VS-1:0][DW-1:0] j_rows;
  logic [NR-1:0][VS-1:0][DW-1:0] j_next;
  logic [NR-1:0]                 valid;
  logic [NR-1:0]                 sigma;
  logic [VS-1:0][CSW-1:0]        col_p;
  logic                          done_p;
  logic [VS-1:0][CSW-1:0]        col_c;
  logic                          done_c;

  row_column_sum_tree #(
    .NUM_ROWS        (NR),
    .VECTOR_SIZE     (VS),
    .DATA_WIDTH      (DW),
    .PIPED           (1),
    .PIPE_STAGE_MASK (3'b111)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .j_rows       (j_rows),
    .j_rows_valid (valid),
    .sigma_bits   (sigma),
    .column_sums  (col_p),
    .done         (done_p)
  );

  row_column_sum_tree #(
    .NUM_ROWS    (NR),
    .VECTOR_SIZE (VS),
    .DATA_WIDTH  (DW),
    .PIPED       (0)
  ) dut_comb (
    .clk          (clk),
    .rst          (rst),
    .j_rows       (j_rows),
    .j_rows_valid (valid),
    .sigma_bits   (sigma),
    .column_sums  (col_c),
    .done         (done_c)
  );

  logic [7:0] as_a;
  logic [7:0] as_b;
  logic       as_sub;
  logic [7:0] as_res;
  logic       as_cout;
  logic       as_ovf;
  logic       as_zero;

  adder_subtractor #(
    .WIDTH (8)
  ) u_as (
    .a        (as_a),
    .b        (as_b),
    .sub      (as_sub),
    .result   (as_res),
    .cout     (as_cout),
    .overflow (as_ovf),
    .zero     (as_zero)
  );

  // ------------------------------------------------------------ scoreboard
  logic [SBW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: {done, sums}. Each column is the plain integer sum of +/-j
  // over the valid rows; an idle row set yields all zeros.
  function automatic logic [SBW-1:0] model(input logic [NR-1:0] v,
                                           input logic [NR-1:0] s,
                                           input logic [NR-1:0][VS-1:0][DW-1:0] j);
    logic [SBW-1:0] res;
    logic [DW-1:0]  e;
    int             sum;
    res = '0;
    if (v != '0) begin
      res[SBW-1] = 1'b1;
      for (int c = 0; c < VS; c++) begin
        sum = 0;
        for (int r = 0; r < NR; r++) begin
          if (v[r]) begin
            e = j[r][c];
            if (s[r]) sum = sum + int'($signed(e));
            else      sum = sum - int'($signed(e));
          end
        end
        res[c*CSW +: CSW] = sum[CSW-1:0];
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [SBW-1:0] obs,
                       input logic [SBW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ driver
  // One cycle: at the falling edge check the pipelined output against the
  // oldest expectation, apply the next row set, then check the
  // combinational instance against the same row set.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] s,
                      input logic do_rst, input string tag);
    logic [SBW-1:0] exp;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      exp = '0;
      check({tag, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_pipe"}, {done_p, col_p}, exp);
    j_rows = j_next;
    valid  = v;
    sigma  = s;
    rst    = do_rst;
    #1;
    check({tag, "_comb"}, {done_c, col_c}, model(v, s, j_next));
    if (do_rst) begin
      // Everything in flight is dropped, including this cycle's row set.
      exp_q.delete();
      repeat (LAT) exp_q.push_back('0);
    end else begin
      exp_q.push_back(model(v, s, j_next));
    end
  endtask

  task automatic fill_j(input logic [DW-1:0] val);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < VS; c++)
        j_next[r][c] = val;
  endtask

  task automatic rand_j();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < VS; c++)
        j_next[r][c] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst    = 1'b1;
    valid  = '0;
    sigma  = '0;
    j_rows = '0;
    j_next = '0;
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;

    // adder_subtractor corner cases
    as_a = 8'h7F; as_b = 8'h01; as_sub = 1'b0; #1;
    check("as_add_res", as_res, 8'h80);
    check("as_add_ovf", as_ovf, 1'b1);
    check("as_add_cout", as_cout, 1'b0);
    as_a = 8'd5; as_b = 8'd5; as_sub = 1'b1; #1;
    check("as_sub_res", as_res, 8'h00);
    check("as_sub_zero", as_zero, 1'b1);
    check("as_sub_cout", as_cout, 1'b1);
    as_a = 8'h80; as_b = 8'h01; as_sub = 1'b1; #1;
    check("as_sub_ovf_res", as_res, 8'h7F);
    check("as_sub_ovf", as_ovf, 1'b1);
    as_a = 8'd3; as_b = 8'd5; as_sub = 1'b1; #1;
    check("as_sub_borrow_res", as_res, 8'hFE);
    check("as_sub_borrow_cout", as_cout, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {done_p, col_p}, '0);
    rst = 1'b0;
    repeat (LAT) exp_q.push_back('0);

    // All rows +1 -> 4 per column
    fill_j(4'h1);
    step(4'b1111, 4'b1111, 1'b0, "all_pos");
    check("all_pos_col0", col_c[0], 8'd4);
    check("all_pos_done", done_c, 1'b1);

    // All rows -8 negated -> +32, no wrap
    fill_j(4'h8);
    step(4'b1111, 4'b0000, 1'b0, "neg_min");
    check("neg_min_col3", col_c[3], 8'd32);

    // Invalid rows ignored: +7 - 3 = 4
    fill_j(4'h5);
    for (int c = 0; c < VS; c++) begin
      j_next[0][c] = 4'h7;
      j_next[2][c] = 4'h3;
    end
    step(4'b0101, 4'b0001, 1'b0, "masked");
    check("masked_col7", col_c[7], 8'd4);

    // Idle cycles with garbage data
    for (int i = 0; i < 6; i++) begin
      rand_j();
      step(4'b0000, NR'($urandom), 1'b0, "idle");
    end
    check("idle_col_zero", col_c, '0);

    // Fill the pipe, then reset mid-flight
    for (int i = 0; i < 3; i++) begin
      rand_j();
      step(4'b1111, NR'($urandom), 1'b0, "prefill");
    end
    rand_j();
    step(4'b1111, 4'b1010, 1'b1, "reset_mid");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      rand_j();
      step(NR'($urandom), NR'($urandom), 1'b0, "random");
    end

    // Back-to-back extremes: every row -8 with +1 spin -> -32
    fill_j(4'h8);
    step(4'b1111, 4'b1111, 1'b0, "neg_extreme");
    check("neg_extreme_col0", col_c[0], 8'hE0);

    // Drain
    for (int i = 0; i < LAT + 1; i++) begin
      fill_j(4'h0);
      step(4'b0000, 4'b0000, 1'b0, "drain");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
